// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM states and RISC-V
// instruction-length encoding constants.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_t;

    localparam logic [1:0]  RV_OP_32B = 2'b11;
    localparam logic [31:0] RV_ILEN_C = 32'd2;

    function automatic logic is_32b_low(input logic [15:0] hw);
        return hw[1:0] == RV_OP_32B;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Spare-halfword register: keeps the upper half of a fetched word and its
// address so the next instruction can start from it without refetching.
module fetch_hold_buf
    import rv_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] load_hw,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [15:0] hw,
    output logic [31:0] pc,
    output logic        is_32b
);

    // clear wins over load so a redirect always empties the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            hw    <= 16'h0000;
            pc    <= 32'h0000_0000;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            hw    <= load_hw;
            pc    <= load_pc;
        end
    end

    assign is_32b = is_32b_low(hw);

endmodule

// File: rtl/fetch_aligner.sv
// Fetch aligner: issues word reads for the current fetch PC and hands decode one
// aligned 32-bit or compressed instruction per handshake.
//
// state  | meaning
// S_REQ  | request word at fetch_pc (held off while a stale response is pending)
// S_WAIT | one request outstanding, waiting for its response
// S_OUT  | instr_* valid, waiting for decode to accept
module fetch_aligner
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          C_EXT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        instr_is_c
);

    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], C_EXT & RESET_PC[1], 1'b0};

    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic         discard, discard_nxt;
    logic [31:0]  word_addr;
    logic         ptr;
    logic         req_fire;

    logic         hold_valid, hold_is_32b, hold_load, hold_clear;
    logic [15:0]  hold_hw;
    logic [31:0]  hold_pc;

    logic         out_load, out_c_nxt;
    logic [31:0]  out_data_nxt, out_pc_nxt;

    logic         unused_redirect_bit0;
    assign unused_redirect_bit0 = redirect_pc[0];

    assign word_addr      = {fetch_pc[31:2], 2'b00};
    assign ptr            = C_EXT && fetch_pc[1];
    assign imem_req_valid = (state == S_REQ) && !discard && !rst;
    assign imem_addr      = word_addr;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign instr_valid    = (state == S_OUT);

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .clear   (hold_clear),
        .load_hw (imem_rsp_data[31:16]),
        .load_pc (word_addr + RV_ILEN_C),
        .valid   (hold_valid),
        .hw      (hold_hw),
        .pc      (hold_pc),
        .is_32b  (hold_is_32b)
    );

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        discard_nxt  = discard && !imem_rsp_valid;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        out_load     = 1'b0;
        out_data_nxt = instr_data;
        out_pc_nxt   = instr_pc;
        out_c_nxt    = instr_is_c;

        if (redirect_valid) begin
            state_nxt    = S_REQ;
            hold_clear   = 1'b1;
            fetch_pc_nxt = {redirect_pc[31:2], C_EXT && redirect_pc[1], 1'b0};
            // a response already on the bus this cycle is simply ignored
            discard_nxt  = req_fire
                        || ((state == S_WAIT) && !imem_rsp_valid)
                        || (discard && !imem_rsp_valid);
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_nxt    = S_OUT;
                        out_load     = 1'b1;
                        fetch_pc_nxt = word_addr + 32'd4;
                        if (hold_valid) begin
                            out_data_nxt = {imem_rsp_data[15:0], hold_hw};
                            out_pc_nxt   = hold_pc;
                            out_c_nxt    = 1'b0;
                            hold_load    = 1'b1;
                        end else if (ptr) begin
                            if (!is_32b_low(imem_rsp_data[31:16])) begin
                                out_data_nxt = {16'h0000, imem_rsp_data[31:16]};
                                out_pc_nxt   = word_addr + RV_ILEN_C;
                                out_c_nxt    = 1'b1;
                            end else begin
                                // upper half starts a 32-bit instr: park it, fetch the rest
                                out_load  = 1'b0;
                                hold_load = 1'b1;
                                state_nxt = S_REQ;
                            end
                        end else if (C_EXT && !is_32b_low(imem_rsp_data[15:0])) begin
                            out_data_nxt = {16'h0000, imem_rsp_data[15:0]};
                            out_pc_nxt   = word_addr;
                            out_c_nxt    = 1'b1;
                            hold_load    = 1'b1;
                        end else begin
                            out_data_nxt = imem_rsp_data;
                            out_pc_nxt   = word_addr;
                            out_c_nxt    = 1'b0;
                        end
                    end
                end
                S_OUT: begin
                    if (instr_ready) begin
                        if (hold_valid && !hold_is_32b) begin
                            out_load     = 1'b1;
                            out_data_nxt = {16'h0000, hold_hw};
                            out_pc_nxt   = hold_pc;
                            out_c_nxt    = 1'b1;
                            hold_clear   = 1'b1;
                        end else begin
                            state_nxt = S_REQ;
                        end
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_FETCH;
            discard    <= 1'b0;
            instr_data <= 32'h0000_0000;
            instr_pc   <= RESET_PC;
            instr_is_c <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            discard  <= discard_nxt;
            if (out_load) begin
                instr_data <= out_data_nxt;
                instr_pc   <= out_pc_nxt;
                instr_is_c <= out_c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios plus a randomized
// run against a halfword-walking reference model of the instruction stream.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_is_c;

    always #5 clk = ~clk;

    fetch_aligner #(.RESET_PC(32'h0000_0100), .C_EXT(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_is_c     (instr_is_c)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat_min = 1, lat_max = 1, ready_pct = 100;
    int          nreq, multi_out;
    logic [31:0] last_req_addr;
    bit          got_instr;
    logic [31:0] got_data, got_pc;
    logic        got_c;

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference: walk memory halfword by halfword from pc
    task automatic model_instr(input logic [31:0] pc, output logic [31:0] data,
                               output logic c, output logic [31:0] npc);
        logic [15:0] lo;
        lo = hw_at(pc);
        if (lo[1:0] == 2'b11) begin
            data = {hw_at(pc + 32'd2), lo};
            c    = 1'b0;
            npc  = pc + 32'd4;
        end else begin
            data = {16'h0000, lo};
            c    = 1'b1;
            npc  = pc + 32'd2;
        end
    endtask

    // One clock: sample handshakes just after the previous negedge, then drive memory side
    task automatic tick();
        bit          acc, fired;
        logic [31:0] a;
        #1;
        acc       = imem_req_valid && imem_req_ready && !rst;
        a         = imem_addr;
        fired     = imem_rsp_valid;
        got_instr = instr_valid && instr_ready && !rst;
        got_data  = instr_data;
        got_pc    = instr_pc;
        got_c     = instr_is_c;
        @(negedge clk);
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (fired) pend = 1'b0;
            if (acc) begin
                if (pend) multi_out++;
                pend          = 1'b1;
                pend_addr     = a;
                pend_cnt      = int'($urandom_range(lat_max, lat_min));
                nreq++;
                last_req_addr = a;
            end
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem[pend_addr[9:2]];
            end else begin
                pend_cnt--;
            end
        end
        imem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
    endtask

    task automatic wait_instr(input int budget, output bit ok, output int used);
        ok   = 1'b0;
        used = 0;
        while (!ok && used < budget) begin
            tick();
            used++;
            if (got_instr) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        repeat (3) tick();
        rst       = 1'b0;
        nreq      = 0;
        multi_out = 0;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        instr_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL reset_instr_data got=%h exp=0", instr_data); end
        total++; if (instr_pc !== 32'h100) begin bad++; $display("FAIL reset_instr_pc got=%h exp=100", instr_pc); end
        total++; if (instr_is_c !== 1'b0) begin bad++; $display("FAIL reset_instr_is_c got=%b exp=0", instr_is_c); end
        rst = 1'b0; nreq = 0; multi_out = 0;
        #1;
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%b exp=1", imem_req_valid); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL first_req_addr got=%h exp=100", imem_addr); end
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL pre_rsp_valid got=%b exp=0", instr_valid); end
        total++; if (instr_pc !== 32'h100) begin bad++; $display("FAIL pre_rsp_pc got=%h exp=100", instr_pc); end
    endtask

    task automatic test_two_words();
        bit ok; int used;
        mem[64] = 32'h0013_0513; mem[65] = 32'h00A5_0533;
        lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
        do_reset();
        wait_instr(20, ok, used);
        total++; if (!ok || used != 3) begin bad++; $display("FAIL w1_latency got_ok=%b cycles=%0d exp=3", ok, used); end
        total++; if (got_data !== 32'h0013_0513 || got_pc !== 32'h100 || got_c !== 1'b0)
            begin bad++; $display("FAIL w1_instr got=%h@%h c=%b exp=00130513@100 c=0", got_data, got_pc, got_c); end
        wait_instr(20, ok, used);
        total++; if (!ok || used != 3) begin bad++; $display("FAIL w2_latency got_ok=%b cycles=%0d exp=3", ok, used); end
        total++; if (got_data !== 32'h00A5_0533 || got_pc !== 32'h104 || got_c !== 1'b0)
            begin bad++; $display("FAIL w2_instr got=%h@%h c=%b exp=00a50533@104 c=0", got_data, got_pc, got_c); end
    endtask

    task automatic test_compressed_pair();
        bit ok; int used;
        mem[64] = 32'h4501_4505; mem[65] = 32'h00A5_0533;
        lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
        do_reset();
        wait_instr(20, ok, used);
        total++; if (!ok || got_data !== 32'h4505 || got_pc !== 32'h100 || got_c !== 1'b1)
            begin bad++; $display("FAIL c1_instr got=%h@%h c=%b exp=4505@100 c=1", got_data, got_pc, got_c); end
        wait_instr(20, ok, used);
        total++; if (!ok || used != 1) begin bad++; $display("FAIL c2_hold_latency got_ok=%b cycles=%0d exp=1", ok, used); end
        total++; if (got_data !== 32'h4501 || got_pc !== 32'h102 || got_c !== 1'b1)
            begin bad++; $display("FAIL c2_instr got=%h@%h c=%b exp=4501@102 c=1", got_data, got_pc, got_c); end
        total++; if (nreq != 1) begin bad++; $display("FAIL c_pair_requests got=%0d exp=1", nreq); end
    endtask

    task automatic test_straddle();
        bit ok; int used;
        mem[64] = 32'h0513_4505; mem[65] = 32'h1234_0013;
        lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
        do_reset();
        wait_instr(20, ok, used);
        total++; if (!ok || got_data !== 32'h4505 || got_pc !== 32'h100 || got_c !== 1'b1)
            begin bad++; $display("FAIL s1_instr got=%h@%h c=%b exp=4505@100 c=1", got_data, got_pc, got_c); end
        wait_instr(20, ok, used);
        total++; if (!ok || got_data !== 32'h0013_0513 || got_pc !== 32'h102 || got_c !== 1'b0)
            begin bad++; $display("FAIL s2_instr got=%h@%h c=%b exp=00130513@102 c=0", got_data, got_pc, got_c); end
        wait_instr(20, ok, used);
        total++; if (!ok || used != 1 || got_data !== 32'h1234 || got_pc !== 32'h106 || got_c !== 1'b1)
            begin bad++; $display("FAIL s3_instr got=%h@%h c=%b cycles=%0d exp=1234@106 c=1 cycles=1", got_data, got_pc, got_c, used); end
        total++; if (nreq != 2) begin bad++; $display("FAIL straddle_requests got=%0d exp=2", nreq); end
    endtask

    task automatic test_redirect();
        bit ok; int used;
        mem[64] = 32'h0013_0513; mem[128] = 32'h4505_0513;
        lat_min = 3; lat_max = 3; ready_pct = 100; instr_ready = 1'b1;
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        tick();
        redirect_valid = 1'b0;
        wait_instr(30, ok, used);
        total++; if (!ok || got_data !== 32'h4505 || got_pc !== 32'h202 || got_c !== 1'b1)
            begin bad++; $display("FAIL redir_instr got=%h@%h c=%b exp=4505@202 c=1", got_data, got_pc, got_c); end
        total++; if (last_req_addr !== 32'h200 || nreq != 2)
            begin bad++; $display("FAIL redir_fetch got_addr=%h reqs=%0d exp_addr=200 reqs=2", last_req_addr, nreq); end
        total++; if (multi_out != 0) begin bad++; $display("FAIL redir_outstanding got=%0d exp=0", multi_out); end
    endtask

    task automatic test_stall();
        bit seen;
        mem[64] = 32'h4501_4505;
        lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b0;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (instr_valid === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL stall_first_valid got=0 exp=1"); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (instr_valid !== 1'b1 || instr_data !== 32'h4505 || instr_pc !== 32'h100)
                begin bad++; $display("FAIL stall_hold got=%b %h@%h exp=1 4505@100", instr_valid, instr_data, instr_pc); end
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", imem_req_valid); end
        end
        instr_ready = 1'b1;
        tick();
        total++; if (!got_instr || got_data !== 32'h4505) begin bad++; $display("FAIL stall_release got=%b %h exp=1 4505", got_instr, got_data); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h102)
            begin bad++; $display("FAIL stall_next got=%b @%h exp=1 @102", instr_valid, instr_pc); end
    endtask

    task automatic test_wrap();
        bit ok; int used;
        mem[255] = 32'h00A5_0533; mem[0] = 32'h0013_0513;
        lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_instr(30, ok, used);
        total++; if (!ok || got_data !== 32'h00A5_0533 || got_pc !== 32'hFFFF_FFFC)
            begin bad++; $display("FAIL wrap_top got=%h@%h exp=00a50533@fffffffc", got_data, got_pc); end
        wait_instr(30, ok, used);
        total++; if (!ok || got_data !== 32'h0013_0513 || got_pc !== 32'h0 || last_req_addr !== 32'h0)
            begin bad++; $display("FAIL wrap_zero got=%h@%h req=%h exp=00130513@0 req=0", got_data, got_pc, last_req_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_data, npc, rpc;
        logic        exp_c;
        bit          redir;
        int          ninstr;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        lat_min = 1; lat_max = 4; ready_pct = 70;
        instr_ready = 1'b1;
        do_reset();
        exp_pc = 32'h100;
        ninstr = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            instr_ready = (int'($urandom_range(99, 0)) < 80);
            redir = (int'($urandom_range(99, 0)) < 3);
            rpc   = $urandom & 32'h0000_03FF;
            redirect_valid = redir;
            redirect_pc    = rpc;
            tick();
            redirect_valid = 1'b0;
            if (got_instr) begin
                model_instr(exp_pc, exp_data, exp_c, npc);
                ninstr++;
                total++; if (got_pc !== exp_pc || got_data !== exp_data || got_c !== exp_c)
                    begin bad++; $display("FAIL rand_instr got=%h@%h c=%b exp=%h@%h c=%b", got_data, got_pc, got_c, exp_data, exp_pc, exp_c); end
                exp_pc = npc;
            end
            if (redir) exp_pc = {rpc[31:1], 1'b0};
        end
        total++; if (ninstr < 100) begin bad++; $display("FAIL rand_progress got=%0d exp>=100", ninstr); end
        total++; if (multi_out != 0) begin bad++; $display("FAIL rand_outstanding got=%0d exp=0", multi_out); end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        instr_ready = 1'b0; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
        nreq = 0; multi_out = 0; last_req_addr = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_two_words();
        test_compressed_pair();
        test_straddle();
        test_redirect();
        test_stall();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
